maxnet_feeder: RTL and testbench

Front-end sequencer for the 4-input, 5-bit maxnet winner-select core. Accepts a serial stream of 5-bit samples over a valid/ready handshake and packs each group of four into the core's X1..X4 inputs. Then it pulses the core's start, waits for the core's completion flag under a watchdog, and returns the selected winner downstream over a second valid/ready handshake. It is the producer/consumer end of the core's load/complete/result interface.

---
 rtl/maxnet_pkg.sv | 20 ++
 rtl/slot_bank.sv | 23 ++
 rtl/maxnet_feeder.sv | 121 ++++++++++++
 tb/tb_maxnet_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared constants, FSM state type and counter sizing for the maxnet feeder.
package maxnet_pkg;

  localparam int DATA_W = 5;
  localparam int NUM_IN = 4;
  localparam int IDX_W  = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // One extra count so the watchdog can hold TIMEOUT itself when saturated.
  function automatic int wcnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/slot_bank.sv
// Write-indexed sample slots feeding the core's X inputs; cleared on reset.
module slot_bank
  import maxnet_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [W-1:0]               d,
  output logic [NUM_IN-1:0][W-1:0]   q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else if (we) begin
      q[idx] <= d;
    end
  end

endmodule

// File: rtl/maxnet_feeder.sv
// Packs four serial samples into the maxnet core, launches a run, watches it
// under a watchdog and hands the winner (or a timeout flag) downstream.
//
// state  | meaning
// FILL   | accepting samples into slots 0..3
// LAUNCH | one-cycle core_start pulse, watchdog cleared
// WAIT   | core iterating; done masked for DONE_MASK cycles
// HOLD   | result presented until taken downstream
module maxnet_feeder #(
  parameter int DATA_W    = maxnet_pkg::DATA_W,
  parameter int TIMEOUT   = 64,
  parameter int DONE_MASK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] X1,
  output logic [DATA_W-1:0] X2,
  output logic [DATA_W-1:0] X3,
  output logic [DATA_W-1:0] X4,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_timeout
);

  import maxnet_pkg::state_t;
  import maxnet_pkg::FILL;
  import maxnet_pkg::LAUNCH;
  import maxnet_pkg::WAIT;
  import maxnet_pkg::HOLD;
  import maxnet_pkg::NUM_IN;
  import maxnet_pkg::IDX_W;
  import maxnet_pkg::wcnt_w;

  localparam int              WW    = wcnt_w(TIMEOUT);
  localparam logic [WW-1:0]   WMAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0]   WLAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0]   WMASK = WW'(DONE_MASK);
  localparam logic [IDX_W-1:0] CLAST = IDX_W'(NUM_IN - 1);

  state_t                         state, state_nxt;
  logic [IDX_W-1:0]               cnt;
  logic [WW-1:0]                  wcnt;
  logic                           run_q;
  logic                           accept;
  logic                           done_ok;
  logic                           tmo;
  logic [NUM_IN-1:0][DATA_W-1:0]  slots;

  // run_q keeps in_ready low until the first edge after reset release, so
  // in_ready never depends combinationally on the reset pin.
  assign in_ready   = (state == FILL) && run_q;
  assign core_start = (state == LAUNCH);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign done_ok    = (state == WAIT) && core_done && (wcnt >= WMASK);
  assign tmo        = (state == WAIT) && !done_ok && (wcnt == WLAST);

  assign X1 = slots[0];
  assign X2 = slots[1];
  assign X3 = slots[2];
  assign X4 = slots[3];

  slot_bank #(.W(DATA_W)) u_slots (
    .clk   (clk),
    .rst_b (rst),
    .we    (accept),
    .idx   (cnt),
    .d     (in_data),
    .q     (slots)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && cnt == CLAST) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (done_ok || tmo) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      run_q <= 1'b0;
      cnt   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (accept) cnt <= cnt + 1'b1;
      if (state == LAUNCH) begin
        wcnt <= '0;
      end else if (state == WAIT && wcnt != WMAX) begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= '0;
      out_timeout <= 1'b0;
    end else if (done_ok) begin
      out_data    <= core_result;
      out_timeout <= 1'b0;
    end else if (tmo) begin
      out_data    <= '0;
      out_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder: fill/launch/wait/hold, masking, watchdog, reset.
module tb_maxnet_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic [4:0] X1, X2, X3, X4;
  logic       core_start;
  logic       core_done;
  logic [4:0] core_result;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_timeout;

  int nvec   = 0;
  int nerr   = 0;
  int nstart = 0;
  int base;

  maxnet_feeder #(.DATA_W(5), .TIMEOUT(64), .DONE_MASK(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .X1          (X1),
    .X2          (X2),
    .X3          (X3),
    .X4          (X4),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_timeout (out_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && core_start) nstart++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed still running, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample and hold it until accepted; leaves in_valid low.
  task automatic send(input logic [4:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 5'h1f;
  endtask

  task automatic chk_x(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_x1"}, X1, a);
    chk({tag, "_x2"}, X2, b);
    chk({tag, "_x3"}, X3, c);
    chk({tag, "_x4"}, X4, d);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    core_done = 1'b0; core_result = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", core_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk_x("rst", 0, 0, 0, 0);
    #9 rst = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);

    // basic run: done five cycles after start, result 17
    out_ready = 1'b1;
    base = nstart;
    send(3); send(17); send(9); send(12);
    chk("t1_start", core_start, 1);
    chk("t1_ready_launch", in_ready, 0);
    chk_x("t1", 3, 17, 9, 12);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_start_gone", core_start, 0);
    tick();
    core_done = 1'b1; core_result = 5'd17;
    chk("t1_not_yet", out_valid, 0);
    tick();
    core_done = 1'b0; core_result = 5'd0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 17);
    chk("t1_out_timeout", out_timeout, 0);
    chk("t1_one_start", nstart - base, 1);
    tick();
    chk("t1_ready_again", in_ready, 1);
    chk("t1_valid_drop", out_valid, 0);

    // stale done held through the mask window, real done at wcnt=4
    core_done = 1'b1; core_result = 5'd7;
    send(1); send(2); send(3); send(4);
    tick(); tick(); tick();
    core_done = 1'b0; core_result = 5'd0;
    chk("t2_stale_ignored", out_valid, 0);
    tick();
    chk("t2_still_wait", out_valid, 0);
    tick();
    core_done = 1'b1; core_result = 5'd22;
    tick();
    core_done = 1'b0; core_result = 5'd0;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 22);
    chk("t2_out_timeout", out_timeout, 0);
    tick();

    // core never finishes: timeout after 64 WAIT cycles
    out_ready = 1'b0;
    send(5); send(6); send(7); send(8);
    for (int i = 0; i < 64; i++) tick();
    chk("t3_before_tmo", out_valid, 0);
    tick();
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 0);
    chk("t3_out_timeout", out_timeout, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // gapped input, fastest done, result held with out_ready low
    send(31); tick(); tick();
    send(0);  tick(); tick();
    send(16); tick(); tick();
    send(1);
    chk_x("t4", 31, 0, 16, 1);
    tick(); tick(); tick();
    core_done = 1'b1; core_result = 5'd31;
    tick();
    core_done = 1'b0; core_result = 5'd4;
    chk("t4_min_latency", out_valid, 1);
    chk("t4_out_data", out_data, 31);
    in_valid = 1'b1; in_data = 5'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_data", out_data, 31);
      chk("t4_hold_x1", X1, 31);
    end
    in_valid = 1'b0;
    chk_x("t4_hold", 31, 0, 16, 1);
    out_ready = 1'b1;
    tick();
    chk("t4_release", in_ready, 1);

    // done arrives on the last watchdog cycle: done wins
    send(10); send(11); send(12); send(13);
    for (int i = 0; i < 64; i++) tick();
    core_done = 1'b1; core_result = 5'd13;
    chk("t6_not_yet", out_valid, 0);
    tick();
    core_done = 1'b0; core_result = 5'd0;
    chk("t6_out_valid", out_valid, 1);
    chk("t6_out_data", out_data, 13);
    chk("t6_out_timeout", out_timeout, 0);
    tick();

    // reset after two accepts, then refill from slot 0
    send(21); send(22);
    rst = 1'b0;
    #1;
    chk("t5a_in_ready", in_ready, 0);
    chk("t5a_out_data", out_data, 0);
    chk_x("t5a", 0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();
    send(2); send(4); send(6); send(8);
    chk("t5a_start", core_start, 1);
    chk_x("t5a_refill", 2, 4, 6, 8);

    // reset mid-WAIT
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("t5b_start", core_start, 0);
    chk("t5b_out_valid", out_valid, 0);
    chk("t5b_in_ready", in_ready, 0);
    chk_x("t5b", 0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();
    send(9); send(10); send(11); send(12);
    chk("t5b_start_again", core_start, 1);
    chk_x("t5b_refill", 9, 10, 11, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
